sad_bank_loader: RTL and testbench
==================================

SAD_BANK_LOADER -- requirements
Module: sad_bank_loader

Interface
REQ-001 Parameter DATA_W, default 32, width of one pixel word written to a bank.
REQ-002 Parameter ADDR_W, default 10, bank address width shared by all 16 DataMemory banks.
REQ-003 Parameter NUM_BANKS, default 16, number of banks filled round-robin; fixed at 16 for this release.
REQ-004 Port Clk input 1: single clock; all state updates on rising edge.
REQ-005 Port Reset input 1: asynchronous, active-low reset.
REQ-006 Port Start input 1: one-cycle pulse that begins a load; sampled only in IDLE.
REQ-007 Port BaseAddr input ADDR_W: first bank address; latched on accepted Start.
REQ-008 Port Length input 16: total words to load; latched on accepted Start.
REQ-009 Port InValid input 1: source presents a word on InData.
REQ-010 Port InData input DATA_W: pixel word.
REQ-011 Port InReady output 1: loader accepts a word when InValid and InReady are both high.
REQ-012 Port MemWrite output NUM_BANKS: one-hot bank write strobes, one per DataMemory instance.
REQ-013 Port Address output ADDR_W: write address, common to all banks.
REQ-014 Port WriteData output DATA_W: write data, common to all banks.
REQ-015 Port Busy output 1: high in LOAD and DONE.
REQ-016 Port Done output 1: one-cycle completion pulse.

Function
REQ-017 FSM states: IDLE, LOAD, DONE.
REQ-018 IDLE->LOAD on Start with Length != 0; IDLE->DONE on Start with Length == 0; Start otherwise ignored.
REQ-019 In LOAD, InReady = 1; InReady = 0 in IDLE and DONE.
REQ-020 Accepted word n (0-based) goes to bank n mod 16 at address BaseAddr + floor(n/16), modulo 2^ADDR_W (wrap-around is silent).
REQ-021 Write latency: a word accepted in cycle k drives MemWrite, Address, WriteData in cycle k+1 for exactly one cycle; all three outputs are registered.
REQ-022 Cycles with InValid low insert no strobe and do not advance bank or address counters.
REQ-023 LOAD->DONE in the cycle following acceptance of word Length-1; Done = 1 for exactly that one DONE cycle, coincident with the final MemWrite strobe.
REQ-024 DONE->IDLE unconditionally after one cycle; Start during LOAD or DONE is ignored, and the latched Length and BaseAddr do not change.
REQ-025 MemWrite is all-zero except in the single cycle following an accepted word; it never has more than one bit set.
REQ-026 WriteData and Address hold their last values when MemWrite is zero.
REQ-027 Word counter is 16 bits; Length = 65535 completes without overflow.

Reset
REQ-028 On Reset low, asynchronously: state = IDLE, MemWrite = 0, Address = 0, WriteData = 0, Busy = 0, Done = 0, InReady = 0, all counters = 0.
REQ-029 Reset asserted mid-LOAD aborts the load: no further strobes, and no Done is issued.
REQ-030 After Reset deasserts, the block waits in IDLE for a fresh Start.

Structure
REQ-031 Shared package holds NUM_BANKS, the ADDR_W/DATA_W defaults, and the state-encoding constants, which the SAD datapath also uses.
REQ-032 One sub-module, sad_bank_sel: a 4-bit bank counter with one-hot decode to the NUM_BANKS strobes; everything else lives in the top module.

Verification
REQ-033 Start, BaseAddr=0, Length=16, InValid held high, InData=0..15 -> words 0..15 written to banks 0..15, each at Address 0; Done in the cycle of the bank-15 strobe.
REQ-034 Length=40, BaseAddr=5, InValid toggling 1/0 each cycle -> 40 strobes, no gaps beyond the InValid gaps; word 39 goes to bank 7 at Address 7; exactly one Done.
REQ-035 BaseAddr=1023, Length=32 -> words 0..15 at Address 1023, words 16..31 at Address 0 (wrap).
REQ-036 Length=0 -> Done one cycle after Start, with no MemWrite activity and InReady never high.
REQ-037 Reset driven low after 10 accepted words of a 64-word load -> all outputs 0 immediately, no Done; a new Start with Length=4 then completes normally.
REQ-038 Second Start pulsed during LOAD with a different Length -> ignored; the original Length count completes.

Source files
------------

// File: rtl/sad_bank_loader_pkg.sv
// Shared constants for the SAD bank loader and the SAD datapath that reads the banks.
// State encodings are plain constants so older datapath code can compare against them directly.
package sad_bank_loader_pkg;

  localparam int NUM_BANKS  = 16;
  localparam int BANK_W     = 4;
  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DATA_W = 32;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/sad_bank_loader_if.sv
// Bundle of the loader's control, source-stream and bank-write signals.
// master drives a load and feeds words; slave is the loader itself.
interface sad_bank_loader_if
  import sad_bank_loader_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) ();

  logic                 Start;
  logic [ADDR_W-1:0]    BaseAddr;
  logic [15:0]          Length;
  logic                 InValid;
  logic [DATA_W-1:0]    InData;
  logic                 InReady;
  logic [NUM_BANKS-1:0] MemWrite;
  logic [ADDR_W-1:0]    Address;
  logic [DATA_W-1:0]    WriteData;
  logic                 Busy;
  logic                 Done;

  modport master (
    output Start, BaseAddr, Length, InValid, InData,
    input  InReady, MemWrite, Address, WriteData, Busy, Done
  );

  modport slave (
    input  Start, BaseAddr, Length, InValid, InData,
    output InReady, MemWrite, Address, WriteData, Busy, Done
  );

endinterface

// File: rtl/sad_bank_sel.sv
// Round-robin bank pointer: 4-bit counter plus one-hot decode to the per-bank strobes.
module sad_bank_sel
  import sad_bank_loader_pkg::*;
#(
  parameter int NUM_BANKS = 16
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 clear,
  input  logic                 advance,
  output logic [BANK_W-1:0]    bank,
  output logic [NUM_BANKS-1:0] strobe
);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      bank <= '0;
    end else if (clear) begin
      bank <= '0;
    end else if (advance) begin
      bank <= bank + 4'd1;
    end
  end

  always_comb begin
    strobe       = '0;
    strobe[bank] = 1'b1;
  end

endmodule

// File: rtl/sad_bank_loader.sv
// Streams Length words into 16 DataMemory banks round-robin, one registered write per accepted word.
// Each full pass over the banks advances the shared bank address by one.
module sad_bank_loader
  import sad_bank_loader_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int NUM_BANKS = sad_bank_loader_pkg::NUM_BANKS
) (
  input  logic             Clk,
  input  logic             Reset,
  sad_bank_loader_if.slave bus
);

  logic [1:0]           state;
  logic [15:0]          length_q;
  logic [15:0]          wordcnt;
  logic [ADDR_W-1:0]    base_q;
  logic [ADDR_W-1:0]    row;
  logic [BANK_W-1:0]    bank;
  logic [NUM_BANKS-1:0] strobe;
  logic [NUM_BANKS-1:0] memwrite_q;
  logic [ADDR_W-1:0]    address_q;
  logic [DATA_W-1:0]    wdata_q;
  logic                 accept;
  logic                 last_word;
  logic                 start_ok;

  assign start_ok  = (state == ST_IDLE) && bus.Start;
  assign accept    = (state == ST_LOAD) && bus.InValid;
  assign last_word = accept && (wordcnt == length_q - 16'd1);

  sad_bank_sel #(
    .NUM_BANKS (NUM_BANKS)
  ) u_bank_sel (
    .Clk     (Clk),
    .Reset   (Reset),
    .clear   (start_ok),
    .advance (accept),
    .bank    (bank),
    .strobe  (strobe)
  );

  // Start is honoured only from IDLE, so the latched geometry stays fixed for the whole load.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state    <= ST_IDLE;
      length_q <= '0;
      base_q   <= '0;
      wordcnt  <= '0;
      row      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.Start) begin
            length_q <= bus.Length;
            base_q   <= bus.BaseAddr;
            wordcnt  <= '0;
            row      <= '0;
            state    <= (bus.Length == 16'd0) ? ST_DONE : ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (accept) begin
            wordcnt <= wordcnt + 16'd1;
            if (bank == 4'hF) begin
              row <= row + 1'b1;
            end
            if (last_word) begin
              state <= ST_DONE;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Address and data only update on a write, so they hold their last value between strobes.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      memwrite_q <= '0;
      address_q  <= '0;
      wdata_q    <= '0;
    end else begin
      memwrite_q <= accept ? strobe : '0;
      if (accept) begin
        address_q <= base_q + row;
        wdata_q   <= bus.InData;
      end
    end
  end

  assign bus.InReady   = (state == ST_LOAD);
  assign bus.Busy      = (state != ST_IDLE);
  assign bus.Done      = (state == ST_DONE);
  assign bus.MemWrite  = memwrite_q;
  assign bus.Address   = address_q;
  assign bus.WriteData = wdata_q;

endmodule

// File: tb/tb_sad_bank_loader.sv
// Directed bench for sad_bank_loader: a source model pushes expected bank writes into a queue
// and a negedge monitor pops and compares them against the DUT's write port.
module tb_sad_bank_loader;
  import sad_bank_loader_pkg::*;

  typedef struct {
    logic [15:0] strobe;
    logic [9:0]  addr;
    logic [31:0] data;
    logic        last;
  } exp_t;

  logic Clk = 1'b0;
  logic Reset;
  exp_t sbq[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   doneCount  = 0;
  int   wordIdx    = 0;
  int   curLen     = 0;
  int   d0;
  logic [9:0] curBase = '0;

  always #5 Clk = ~Clk;

  sad_bank_loader_if #(.DATA_W(32), .ADDR_W(10)) bus ();

  sad_bank_loader #(.DATA_W(32), .ADDR_W(10), .NUM_BANKS(16)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Write port monitor: every strobe must match the oldest outstanding expectation.
  always @(negedge Clk) begin
    if (Reset === 1'b1) begin
      if (bus.Done === 1'b1) doneCount++;
      if (bus.MemWrite !== 16'h0) begin
        if (sbq.size() == 0) begin
          checkOutput("unexpected_strobe", 64'(bus.MemWrite), 64'h0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          checkOutput("strobe", 64'(bus.MemWrite), 64'(e.strobe));
          checkOutput("address", 64'(bus.Address), 64'(e.addr));
          checkOutput("wdata", 64'(bus.WriteData), 64'(e.data));
          checkOutput("done_with_strobe", 64'(bus.Done), 64'(e.last));
        end
      end
    end
  end

  task automatic startLoad(input logic [9:0] base, input int len);
    @(posedge Clk) #1;
    bus.Start    = 1'b1;
    bus.BaseAddr = base;
    bus.Length   = 16'(len);
    curBase      = base;
    curLen       = len;
    wordIdx      = 0;
    @(posedge Clk) #1;
    bus.Start = 1'b0;
  endtask

  // Drive one cycle of the source; a valid word is accepted at the next rising edge.
  task automatic applyStimulus(input logic valid);
    exp_t e;
    bus.InValid = valid;
    if (valid) begin
      bus.InData = $urandom;
      e.strobe   = 16'h1 << (wordIdx % 16);
      e.addr     = 10'(int'(curBase) + wordIdx / 16);
      e.data     = bus.InData;
      e.last     = (wordIdx == curLen - 1);
      sbq.push_back(e);
      wordIdx++;
    end
    @(posedge Clk) #1;
  endtask

  task automatic waitDrain(input string tag);
    int n;
    bus.InValid = 1'b0;
    n = 0;
    while (sbq.size() != 0 && n < 40) begin
      @(negedge Clk);
      n++;
    end
    checkOutput(tag, 64'(sbq.size()), 64'h0);
    @(posedge Clk) #1;
    @(posedge Clk) #1;
    checkOutput({tag, "_idle"}, 64'(bus.Busy), 64'h0);
  endtask

  initial begin
    Reset        = 1'b0;
    bus.Start    = 1'b0;
    bus.BaseAddr = '0;
    bus.Length   = '0;
    bus.InValid  = 1'b0;
    bus.InData   = '0;
    #2;
    checkOutput("rst_memwrite", 64'(bus.MemWrite), 64'h0);
    checkOutput("rst_address", 64'(bus.Address), 64'h0);
    checkOutput("rst_wdata", 64'(bus.WriteData), 64'h0);
    checkOutput("rst_busy", 64'(bus.Busy), 64'h0);
    checkOutput("rst_done", 64'(bus.Done), 64'h0);
    checkOutput("rst_inready", 64'(bus.InReady), 64'h0);
    #20;
    @(negedge Clk) Reset = 1'b1;

    // 16 words, InValid held high: one full pass over the banks at address 0.
    d0 = doneCount;
    startLoad(10'd0, 16);
    checkOutput("t1_inready", 64'(bus.InReady), 64'h1);
    checkOutput("t1_busy", 64'(bus.Busy), 64'h1);
    for (int i = 0; i < 16; i++) applyStimulus(1'b1);
    waitDrain("t1_drain");
    checkOutput("t1_done_count", 64'(doneCount - d0), 64'h1);

    // 40 words with InValid toggling; word 39 lands in bank 7 at address 7.
    d0 = doneCount;
    startLoad(10'd5, 40);
    for (int c = 0; wordIdx < 40 && c < 200; c++) applyStimulus(c % 2 == 0);
    waitDrain("t2_drain");
    checkOutput("t2_done_count", 64'(doneCount - d0), 64'h1);
    checkOutput("t2_last_addr", 64'(bus.Address), 64'h7);

    // Address wrap from 1023 to 0 after the first pass.
    d0 = doneCount;
    startLoad(10'd1023, 32);
    for (int i = 0; i < 32; i++) applyStimulus(1'b1);
    waitDrain("t3_drain");
    checkOutput("t3_done_count", 64'(doneCount - d0), 64'h1);

    // Zero-length load: Done one cycle after Start, no writes, never ready.
    d0 = doneCount;
    @(posedge Clk) #1;
    bus.Start  = 1'b1;
    bus.Length = 16'd0;
    checkOutput("t4_inready_start", 64'(bus.InReady), 64'h0);
    @(posedge Clk) #1;
    bus.Start = 1'b0;
    checkOutput("t4_done", 64'(bus.Done), 64'h1);
    checkOutput("t4_inready_done", 64'(bus.InReady), 64'h0);
    checkOutput("t4_memwrite", 64'(bus.MemWrite), 64'h0);
    @(posedge Clk) #1;
    checkOutput("t4_done_clear", 64'(bus.Done), 64'h0);
    checkOutput("t4_busy_clear", 64'(bus.Busy), 64'h0);
    checkOutput("t4_done_count", 64'(doneCount - d0), 64'h1);

    // Reset after 10 words of a 64-word load aborts it without a Done.
    d0 = doneCount;
    startLoad(10'd3, 64);
    for (int i = 0; i < 10; i++) applyStimulus(1'b1);
    bus.InValid = 1'b0;
    @(negedge Clk) #1;
    checkOutput("t5_pending", 64'(sbq.size()), 64'h0);
    Reset = 1'b0;
    #1;
    checkOutput("t5_memwrite", 64'(bus.MemWrite), 64'h0);
    checkOutput("t5_address", 64'(bus.Address), 64'h0);
    checkOutput("t5_wdata", 64'(bus.WriteData), 64'h0);
    checkOutput("t5_busy", 64'(bus.Busy), 64'h0);
    checkOutput("t5_inready", 64'(bus.InReady), 64'h0);
    repeat (3) @(posedge Clk);
    @(negedge Clk) Reset = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    checkOutput("t5_stays_idle", 64'(bus.Busy), 64'h0);
    checkOutput("t5_no_done", 64'(doneCount - d0), 64'h0);
    startLoad(10'd100, 4);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1);
    waitDrain("t5_reload_drain");
    checkOutput("t5_reload_done", 64'(doneCount - d0), 64'h1);

    // A second Start during LOAD must not change the length or base.
    d0 = doneCount;
    startLoad(10'd20, 24);
    for (int i = 0; i < 24; i++) begin
      if (i == 3) begin
        bus.Start    = 1'b1;
        bus.Length   = 16'd3;
        bus.BaseAddr = 10'd500;
      end else begin
        bus.Start = 1'b0;
      end
      applyStimulus(1'b1);
    end
    bus.Start = 1'b0;
    waitDrain("t6_drain");
    checkOutput("t6_done_count", 64'(doneCount - d0), 64'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
